// File: rtl/imem_arbiter.sv
// Shares one instruction-memory port between fetch (read) and the program loader (write).
// Optional write protection of the low interrupt area: define IMEM_WRITE_PROTECT_EN.
module imem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 4,
    parameter int PROT_LIMIT   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_grant,
    output logic              fetch_stall,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              boot_done,
    output logic              err_wp,
    output logic              mem_cs,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {BOOT, RUN} state_e;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_e            state_q, state_d;
    logic [3:0]        starve_q, starve_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic [DATA_W-1:0] fetch_data_q, fetch_data_d;
    logic              err_wp_q, err_wp_d;
    logic              f_gnt, ld_gnt, wp_hit;

`ifdef IMEM_WRITE_PROTECT_EN
    // Boot-time writes may populate the interrupt area; only RUN writes are blocked.
    assign wp_hit = (state_q == RUN) && ld_gnt && (ld_addr < ADDR_W'(PROT_LIMIT));
`else
    assign wp_hit = 1'b0;
`endif

    always_comb begin
        f_gnt         = 1'b0;
        ld_gnt        = 1'b0;
        state_d       = state_q;
        starve_d      = starve_q;
        fetch_valid_d = 1'b0;
        fetch_data_d  = fetch_data_q;
        err_wp_d      = wp_hit;

        if (state_q == BOOT) begin
            ld_gnt = ld_valid;
            if (ld_valid && ld_last) begin
                state_d = RUN;
            end
        end else if (fetch_req && ld_valid) begin
            ld_gnt = (starve_q == STARVE_MAX);
            f_gnt  = ~ld_gnt;
        end else begin
            f_gnt  = fetch_req;
            ld_gnt = ld_valid;
        end

        // Counts consecutive lost cycles of a pending loader beat.
        if (!ld_valid || ld_gnt) begin
            starve_d = 4'd0;
        end else if (starve_q < STARVE_MAX) begin
            starve_d = starve_q + 4'd1;
        end

        if (f_gnt) begin
            fetch_valid_d = 1'b1;
            fetch_data_d  = mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= BOOT;
            starve_q      <= 4'd0;
            fetch_valid_q <= 1'b0;
            fetch_data_q  <= '0;
            err_wp_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            starve_q      <= starve_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_data_q  <= fetch_data_d;
            err_wp_q      <= err_wp_d;
        end
    end

    assign fetch_grant = f_gnt;
    assign fetch_stall = fetch_req & ~f_gnt;
    assign fetch_valid = fetch_valid_q;
    assign fetch_data  = fetch_data_q;
    assign ld_ready    = ld_gnt;
    assign boot_done   = (state_q == RUN);
    assign err_wp      = err_wp_q;

    // A protected loader beat is acknowledged but leaves the memory port idle.
    assign mem_read  = f_gnt;
    assign mem_write = ld_gnt & ~wp_hit;
    assign mem_cs    = mem_read | mem_write;
    assign mem_addr  = mem_read  ? fetch_addr :
                       mem_write ? ld_addr    : '0;
    assign mem_wdata = mem_write ? ld_data : '0;

endmodule
